// File: rtl/alu_cmd_seq_if.sv
// rtl/alu_cmd_seq_if.sv - request, ALU drive and response signals of the ALU command sequencer
interface alu_cmd_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cmd;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_cmd;
  logic        alu_oe;
  logic [15:0] alu_dout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [7:0]  op_count;

  modport master (
    output req_valid, req_cmd, req_a, req_b, rsp_ready, alu_dout,
    input  req_ready, alu_a, alu_b, alu_cmd, alu_oe, rsp_valid, rsp_data, rsp_err, op_count
  );

  modport slave (
    input  req_valid, req_cmd, req_a, req_b, rsp_ready, alu_dout,
    output req_ready, alu_a, alu_b, alu_cmd, alu_oe, rsp_valid, rsp_data, rsp_err, op_count
  );
endinterface

// File: rtl/alu_cmd_seq.sv
// rtl/alu_cmd_seq.sv - sequences one ALU command at a time: drive operands, settle, capture, respond
module alu_cmd_seq #(
  parameter int unsigned SETTLE = 1
) (
  input logic          clk,
  input logic          rst_n,
  alu_cmd_seq_if.slave bus
);

  localparam logic [3:0] LP_LAST = 4'(SETTLE - 1);
  localparam logic [3:0] LP_DIV  = 4'b0101;

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [7:0]  r_alu_a, w_alu_a_nxt;
  logic [7:0]  r_alu_b, w_alu_b_nxt;
  logic [3:0]  r_alu_cmd, w_alu_cmd_nxt;
  logic [15:0] r_rsp_data, w_rsp_data_nxt;
  logic        r_rsp_err, w_rsp_err_nxt;
  logic [7:0]  r_op_count, w_op_count_nxt;
  logic        w_div_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_cmd  <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_op_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_alu_a    <= w_alu_a_nxt;
      r_alu_b    <= w_alu_b_nxt;
      r_alu_cmd  <= w_alu_cmd_nxt;
      r_rsp_data <= w_rsp_data_nxt;
      r_rsp_err  <= w_rsp_err_nxt;
      r_op_count <= w_op_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_alu_a_nxt    = r_alu_a;
    w_alu_b_nxt    = r_alu_b;
    w_alu_cmd_nxt  = r_alu_cmd;
    w_rsp_data_nxt = r_rsp_data;
    w_rsp_err_nxt  = r_rsp_err;
    w_op_count_nxt = r_op_count;
    w_div_zero     = (bus.req_cmd == LP_DIV) && (bus.req_b == 8'h00);

    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_alu_a_nxt   = bus.req_a;
          w_alu_b_nxt   = bus.req_b;
          w_alu_cmd_nxt = bus.req_cmd;
          w_cnt_nxt     = '0;
          // Divide by zero never reaches the ALU; answer straight away.
          if (w_div_zero) begin
            w_rsp_data_nxt = 16'h0000;
            w_rsp_err_nxt  = 1'b1;
            w_state_nxt    = ST_RESP;
          end else begin
            w_state_nxt = ST_DRIVE;
          end
        end
      end
      ST_DRIVE: begin
        if (r_cnt == LP_LAST) begin
          w_rsp_data_nxt = bus.alu_dout;
          w_rsp_err_nxt  = 1'b0;
          w_state_nxt    = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_op_count_nxt = r_op_count + 8'd1;
          w_state_nxt    = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.alu_oe    = (r_state == ST_DRIVE);
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_cmd   = r_alu_cmd;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.op_count  = r_op_count;

endmodule

// File: doc/alu_cmd_seq.md
ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 SHALL have parameter SETTLE, default 1, giving the number of cycles (1..15) that ALU operands are held before the result is sampled.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  command request valid.
REQ-005 SHALL have port req_ready  output  1  sequencer can accept a command.
REQ-006 SHALL have port req_cmd  input  4  ALU opcode (0000 ADD .. 1111 BUF; 0101 = DIV).
REQ-007 SHALL have port req_a  input  8  operand A.
REQ-008 SHALL have port req_b  input  8  operand B.
REQ-009 SHALL have port alu_a  output  8  registered operand A to ALU.
REQ-010 SHALL have port alu_b  output  8  registered operand B to ALU.
REQ-011 SHALL have port alu_cmd  output  4  registered opcode to ALU.
REQ-012 SHALL have port alu_oe  output  1  ALU output enable.
REQ-013 SHALL have port alu_dout  input  16  ALU result bus (high-Z when alu_oe low).
REQ-014 SHALL have port rsp_valid  output  1  result valid.
REQ-015 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-016 SHALL have port rsp_data  output  16  captured result.
REQ-017 SHALL have port rsp_err  output  1  result is an error (divide by zero).
REQ-018 SHALL have port op_count  output  8  count of completed responses.

Function
REQ-019 SHALL implement states IDLE, DRIVE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 IDLE: on req_valid=1, SHALL register req_cmd/req_a/req_b onto alu_cmd/alu_a/alu_b and go to DRIVE; otherwise stay in IDLE.
REQ-021 IDLE with req_valid=1, req_cmd=0101, req_b=0: SHALL skip DRIVE, go to RESP with rsp_data=16'h0000, rsp_err=1; alu_oe SHALL stay 0 for that command.
REQ-022 DRIVE: alu_oe SHALL be 1 for exactly SETTLE cycles; alu_a/b/cmd SHALL be stable throughout.
REQ-023 On the closing edge of the last DRIVE cycle, alu_dout SHALL be latched into rsp_data, rsp_err cleared, state to RESP.
REQ-024 alu_oe SHALL be 0 in IDLE and RESP; alu_dout SHALL never be sampled while alu_oe=0.
REQ-025 RESP: rsp_valid SHALL be 1; rsp_data/rsp_err SHALL hold stable until rsp_valid&&rsp_ready.
REQ-026 On rsp_valid&&rsp_ready, SHALL return to IDLE, drop rsp_valid next cycle, and increment op_count by 1 (errors included).
REQ-027 op_count SHALL wrap 8'hFF -> 8'h00.
REQ-028 Latency: accept at edge N -> rsp_valid high from cycle N+SETTLE+1; error path: rsp_valid high from cycle N+1.
REQ-029 Throughput: at most one command per SETTLE+2 cycles; no request is dropped (accepted only when req_ready=1).
REQ-030 alu_a/b/cmd and rsp_data SHALL retain their last values in IDLE.
REQ-031 req_* changes while req_ready=0 SHALL have no effect.

Reset
REQ-032 rst_n=0 at a rising edge SHALL force state IDLE, alu_a=0, alu_b=0, alu_cmd=0, alu_oe=0, rsp_valid=0, rsp_data=0, rsp_err=0, op_count=0; req_ready=1 from the first cycle after reset release.
REQ-033 Reset in DRIVE or RESP SHALL abandon the command without producing a response or counting it.

Verification (bench instantiates the team's 8-bit ALU on the alu_* ports)
REQ-034 ADD a=8'h12 b=8'h34, rsp_ready=1 -> rsp_data=16'h0046, rsp_err=0, rsp_valid at cycle N+2 (SETTLE=1), op_count=1.
REQ-035 MUL a=8'hFF b=8'hFF -> rsp_data=16'hFE01; SUB a=8'h05 b=8'h07 -> rsp_data=16'hFFFE.
REQ-036 DIV a=8'h40 b=8'h00 -> rsp_err=1, rsp_data=16'h0000, alu_oe never 1, rsp_valid at N+1.
REQ-037 rsp_ready held 0 for 3 cycles after rsp_valid -> rsp_data stable, req_ready=0, req_valid pulses ignored, op_count unchanged until handshake.
REQ-038 SETTLE=3, DIV a=8'hC8 b=8'h0A -> alu_oe high exactly 3 cycles, rsp_data=16'h0014 at N+4.
REQ-039 rst_n=0 during DRIVE -> next cycle alu_oe=0, rsp_valid=0, op_count=0, req_ready=1 after release; 256 completed ops -> op_count=8'h00.
